hex_display_scheduler: RTL and testbench
========================================

// Module: hex_display_scheduler
// PURPOSE
//   Shares the six 7-segment displays (hex0..hex5) between two requesters
//   (0 = Nios score writer, 1 = local paddle/debug logic) over a req/ack handshake.
//   Round-robin arbitration with a minimum dwell time, so one source cannot make
//   the other's digits unreadable. Sits between the requesters and the board pins.
// PARAMETERS
//   HOLD_CYCLES  50_000_000  minimum cycles an owner keeps the display (1 s @ 50 MHz); >=2
//   CNT_W        26          dwell counter width; 2**CNT_W > HOLD_CYCLES
// PORTS
//   clk_clk       in   1   system clock; all logic on rising edge
//   reset_reset   in   1   asynchronous, active-high reset
//   req           in   2   req[i]: requester i has a value to show; held until ack[i]
//   value0        in   24  requester 0 digits, nibble n -> hex n (hex0 = [3:0])
//   value1        in   24  requester 1 digits, same packing
//   blank0        in   6   requester 0 per-digit blank mask, 1 = digit dark
//   blank1        in   6   requester 1 per-digit blank mask
//   ack           out  2   one-cycle pulse: value/blank of requester i captured
//   owner         out  1   requester whose data is currently displayed
//   busy          out  1   high while in DWELL
//   hex0..hex5    out  7   each 7 bits, active-low segments {g,f,e,d,c,b,a}
// BEHAVIOUR
//   Reset (async): state IDLE, owner=0, last=1 (so req0 wins first tie), ack=0,
//     busy=0, counter=0, latched value=0, blank=6'h3F, all hex = 7'h7F (dark).
//   States: IDLE, DWELL. All outputs registered.
//   IDLE: on edge where any req high: pick src = only requester, or if both,
//     the one != last. At that edge: latch value/blank of src, owner<=src,
//     last<=src, ack[src]<=1 for one cycle, counter<=HOLD_CYCLES-1, -> DWELL.
//   DWELL: counter decrements each cycle, busy=1.
//     - req[owner] high while ack[owner] low: re-latch owner's data, pulse
//       ack[owner]; counter NOT reloaded (refresh, not re-grant).
//     - req[~owner] ignored (no ack) until counter==0.
//     - counter==0 edge: if req[~owner] -> grant ~owner (as IDLE grant, reload
//       counter, stay DWELL); else if req[owner] -> grant owner, reload;
//       else -> IDLE, display keeps owner's data.
//   Handshake: requester must drop req in the cycle ack is high; req still
//     high at the following edge is a new request. value/blank stable while req.
//   ack is never high for both bits in the same cycle.
//   Latency: req sampled at edge k -> ack high and hex updated after edge k
//     (decode registered from the latch input mux, same edge). No extra delay.
//   Decode: nibble 0-F to standard hex glyphs (0=7'h40,1=7'h79,...,8=7'h00,
//     A=7'h08,b=7'h03,C=7'h46,d=7'h21,E=7'h06,F=7'h0E); blank bit -> 7'h7F.
//   Reset mid-DWELL: immediately dark, IDLE, any pending ack dropped.
// TESTING
//   1 Reset, no req -> hex0..5=7'h7F, ack=0, busy=0, owner=0 held indefinitely.
//   2 req=01, value0=24'h000123, blank0=6'h38 -> ack=01 one cycle; hex0=7'h30,
//     hex1=7'h24, hex2=7'h79, hex3..5=7'h7F; busy=1 for HOLD_CYCLES cycles.
//   3 HOLD_CYCLES=4; owner 0 in DWELL, req1 raised 1 cycle after grant -> no
//     ack[1] until counter==0; then ack=10, owner=1, hex shows value1.
//   4 Both req on same edge after reset -> requester 0 granted; both again at
//     dwell end with owner 0 -> requester 1 granted (round-robin).
//   5 Owner refresh: owner 1 in DWELL re-asserts req with value1=24'hABCDEF ->
//     ack=10 next edge, hex0=7'h0E..hex5=7'h08, counter not reloaded.
//   6 Assert reset_reset mid-DWELL with ack pending -> all hex 7'h7F, ack=0,
//     state IDLE without waiting for a clock edge.

Source files
------------

// File: rtl/hex_display_scheduler_if.sv
// Requester-side bundle for the hex display scheduler: per-requester digits,
// blank masks and the req/ack pair.
interface hex_display_scheduler_if;
  // Handshake: req[i] is held high with value/blank stable until ack[i] pulses;
  // the requester drops req[i] in the ack cycle, and a req still high at the
  // following edge counts as a new request. ack is one-hot or zero.
  logic [1:0]  req;
  logic [23:0] value0;
  logic [23:0] value1;
  logic [5:0]  blank0;
  logic [5:0]  blank1;
  logic [1:0]  ack;

  modport master (output req, value0, value1, blank0, blank1, input ack);
  modport slave  (input req, value0, value1, blank0, blank1, output ack);
endinterface

// File: rtl/hex_display_scheduler.sv
// Round-robin owner of the six 7-segment displays with a minimum dwell per grant.
// Segment outputs are registered straight from the grant mux, so a grant shows up with its ack.
module hex_display_scheduler #(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int CNT_W       = 26
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset,
  hex_display_scheduler_if.slave  bus,
  output logic                    owner,
  output logic                    busy,
  output logic [6:0]              hex0,
  output logic [6:0]              hex1,
  output logic [6:0]              hex2,
  output logic [6:0]              hex3,
  output logic [6:0]              hex4,
  output logic [6:0]              hex5,
  output logic                    state_dbg
);

  typedef enum logic [0:0] {IDLE = 1'b0, DWELL = 1'b1} state_t;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t           state_q, state_d;
  logic             owner_q, last_q;
  logic [1:0]       ack_q;
  logic [CNT_W-1:0] cnt_q;
  logic [6:0]       hex_q [6];
  logic [6:0]       hex_d [6];
  logic             grant, reload, src;
  logic [23:0]      sel_value;
  logic [5:0]       sel_blank;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;  4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;  4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;  4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;  4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    reload  = 1'b0;
    src     = owner_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          grant   = 1'b1;
          reload  = 1'b1;
          state_d = DWELL;
          // On a tie the requester that did not win last time goes first.
          src     = (&bus.req) ? ~last_q : bus.req[1];
        end
      end
      DWELL: begin
        if (cnt_q == '0) begin
          if (bus.req[~owner_q]) begin
            grant  = 1'b1;
            reload = 1'b1;
            src    = ~owner_q;
          end else if (bus.req[owner_q]) begin
            grant  = 1'b1;
            reload = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (bus.req[owner_q] && !ack_q[owner_q]) begin
          // Owner refresh: new digits, but the dwell window is not extended.
          grant = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    sel_value = src ? bus.value1 : bus.value0;
    sel_blank = src ? bus.blank1 : bus.blank0;
    for (int n = 0; n < 6; n++) begin
      hex_d[n] = sel_blank[n] ? 7'h7F : glyph(sel_value[4*n +: 4]);
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      ack_q   <= 2'b00;
      cnt_q   <= '0;
      for (int n = 0; n < 6; n++) hex_q[n] <= 7'h7F;
    end else begin
      state_q <= state_d;
      ack_q   <= grant ? (src ? 2'b10 : 2'b01) : 2'b00;
      if (grant) begin
        owner_q <= src;
        last_q  <= src;
        for (int n = 0; n < 6; n++) hex_q[n] <= hex_d[n];
      end
      if (reload) begin
        cnt_q <= RELOAD;
      end else if (state_q == DWELL && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign bus.ack   = ack_q;
  assign owner     = owner_q;
  assign busy      = (state_q == DWELL);
  assign state_dbg = state_q;
  assign hex0      = hex_q[0];
  assign hex1      = hex_q[1];
  assign hex2      = hex_q[2];
  assign hex3      = hex_q[3];
  assign hex4      = hex_q[4];
  assign hex5      = hex_q[5];

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Randomised and directed bench for hex_display_scheduler with a cycle-stamped
// grant scoreboard and a reference model of ownership, dwell windows and glyphs.
module tb_hex_display_scheduler;

  localparam int HOLD  = 4;
  localparam int CNT_W = 3;
  localparam int W     = 61;  // {stamp[15:0], ack[1:0], owner, hex5..hex0}

  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic       clk = 1'b0;
  logic       rst;
  logic       owner, busy, state_dbg;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;

  hex_display_scheduler_if bus ();

  hex_display_scheduler #(.HOLD_CYCLES(HOLD), .CNT_W(CNT_W)) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .bus         (bus),
    .owner       (owner),
    .busy        (busy),
    .hex0        (hex0),
    .hex1        (hex1),
    .hex2        (hex2),
    .hex3        (hex3),
    .hex4        (hex4),
    .hex5        (hex5),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // ---------------- reference model + scoreboard ----------------
  int         errors = 0;
  int         checks = 0;
  logic [W-1:0] exp_q [$];

  bit         m_dwell;
  logic       m_owner, m_last;
  logic [1:0] m_ack;
  int         m_end;         // edge index at which the current dwell window expires
  logic [6:0] m_hex [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [41:0] model_hex();
    return {m_hex[5], m_hex[4], m_hex[3], m_hex[2], m_hex[1], m_hex[0]};
  endfunction

  function automatic logic [41:0] dut_hex();
    return {hex5, hex4, hex3, hex2, hex1, hex0};
  endfunction

  task automatic model_reset();
    m_dwell = 1'b0;
    m_owner = 1'b0;
    m_last  = 1'b1;
    m_ack   = 2'b00;
    m_end   = 0;
    for (int d = 0; d < 6; d++) m_hex[d] = 7'h7F;
    exp_q.delete();
  endtask

  // Predicts the effect of the coming rising edge from the inputs now on the bus.
  task automatic model_step();
    int          nxt;
    bit          grant, reload;
    logic        src;
    logic [23:0] v;
    logic [5:0]  b;
    nxt    = edge_cnt + 1;
    grant  = 1'b0;
    reload = 1'b0;
    src    = m_owner;
    if (!m_dwell) begin
      if (bus.req != 2'b00) begin
        grant  = 1'b1;
        reload = 1'b1;
        src    = (bus.req == 2'b11) ? ~m_last : bus.req[1];
      end
    end else if (nxt == m_end) begin
      if (bus.req[~m_owner]) begin
        grant = 1'b1; reload = 1'b1; src = ~m_owner;
      end else if (bus.req[m_owner]) begin
        grant = 1'b1; reload = 1'b1; src = m_owner;
      end else begin
        m_dwell = 1'b0;
      end
    end else if (bus.req[m_owner] && !m_ack[m_owner]) begin
      grant = 1'b1;
      src   = m_owner;
    end
    if (grant) begin
      v       = src ? bus.value1 : bus.value0;
      b       = src ? bus.blank1 : bus.blank0;
      m_owner = src;
      m_last  = src;
      m_ack   = src ? 2'b10 : 2'b01;
      for (int d = 0; d < 6; d++) m_hex[d] = b[d] ? 7'h7F : GLYPH[v[4*d +: 4]];
      if (reload) begin
        m_end   = nxt + HOLD;
        m_dwell = 1'b1;
      end
      exp_q.push_back({16'(nxt), m_ack, m_owner, model_hex()});
    end else begin
      m_ack = 2'b00;
    end
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    logic [W-1:0] e;
    #1;
    if (!rst) begin
      chk("cycle_state", {18'd0, bus.ack, owner, busy, dut_hex()},
                         {18'd0, m_ack, m_owner, m_dwell, model_hex()});
      chk("ack_exclusive", {63'd0, bus.ack == 2'b11}, 64'd0);
      if (bus.ack != 2'b00) begin
        if (exp_q.size() == 0) begin
          chk("grant_unexpected", {62'd0, bus.ack}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("grant", {3'd0, 16'(edge_cnt), bus.ack, owner, dut_hex()}, {3'd0, e});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step_req(input logic [1:0] raise, input logic [23:0] v0, input logic [23:0] v1,
                          input logic [5:0] b0, input logic [5:0] b1);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (bus.req[i] && bus.ack[i]) begin
        bus.req[i] = 1'b0;
      end else if (!bus.req[i] && raise[i]) begin
        bus.req[i] = 1'b1;
        if (i == 0) begin bus.value0 = v0; bus.blank0 = b0; end
        else        begin bus.value1 = v1; bus.blank1 = b1; end
      end
    end
    model_step();
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) step_req(2'b00, 24'h0, 24'h0, 6'h0, 6'h0);
  endtask

  task automatic apply_reset();
    rst     = 1'b1;
    bus.req = 2'b00;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic sample();
    @(posedge clk);
    #2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int busy_cnt;
    rst        = 1'b1;
    bus.req    = 2'b00;
    bus.value0 = 24'h0;
    bus.value1 = 24'h0;
    bus.blank0 = 6'h0;
    bus.blank1 = 6'h0;
    model_reset();
    #1;
    chk("reset_outputs", {20'd0, bus.ack, owner, busy, dut_hex()}, {20'd0, 2'b00, 1'b0, 1'b0, {6{7'h7F}}});
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle_cycles(6);

    // Single requester grant with partial blanking, then dwell length.
    step_req(2'b01, 24'h000123, 24'h0, 6'h38, 6'h0);
    sample();
    chk("t2_hex", {22'd0, dut_hex()}, {22'd0, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30});
    chk("t2_ack", {62'd0, bus.ack}, 64'd1);
    busy_cnt = busy ? 1 : 0;
    for (int k = 0; k < HOLD + 2; k++) begin
      step_req(2'b00, 24'h0, 24'h0, 6'h0, 6'h0);
      sample();
      if (busy) busy_cnt++;
    end
    chk("t2_busy_len", 64'(busy_cnt), 64'(HOLD));

    // Other requester arrives mid-dwell and must wait for the window to end.
    apply_reset();
    step_req(2'b01, 24'h111111, 24'h0, 6'h00, 6'h0);
    step_req(2'b10, 24'h0, 24'h654321, 6'h0, 6'h00);
    idle_cycles(HOLD);
    sample();
    chk("t3_owner", {63'd0, owner}, 64'd1);
    idle_cycles(HOLD + 2);

    // Simultaneous requests after reset: 0 first, then round-robin to 1.
    apply_reset();
    step_req(2'b11, 24'h222222, 24'h333333, 6'h00, 6'h00);
    sample();
    chk("t4_tie_first", {63'd0, owner}, 64'd0);
    for (int k = 0; k < HOLD + 1; k++) step_req(2'b11, 24'h222222, 24'h333333, 6'h00, 6'h00);
    idle_cycles(2 * HOLD + 2);

    // Owner refresh without extending the window.
    apply_reset();
    step_req(2'b10, 24'h0, 24'h123456, 6'h0, 6'h00);
    step_req(2'b00, 24'h0, 24'h0, 6'h0, 6'h0);
    step_req(2'b10, 24'h0, 24'hABCDEF, 6'h0, 6'h00);
    sample();
    chk("t5_hex", {22'd0, dut_hex()}, {22'd0, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E});
    chk("t5_ack", {62'd0, bus.ack}, 64'd2);
    idle_cycles(HOLD + 2);

    // Asynchronous reset while an ack is pending.
    step_req(2'b01, 24'h456789, 24'h0, 6'h00, 6'h0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_reset", {19'd0, bus.ack, owner, busy, state_dbg, dut_hex()},
                          {19'd0, 2'b00, 1'b0, 1'b0, 1'b0, {6{7'h7F}}});
    bus.req = 2'b00;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(3);

    // Randomised traffic against the model.
    for (int k = 0; k < 400; k++) begin
      step_req(2'($urandom_range(0, 3)), 24'($urandom), 24'($urandom),
               6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
    end
    bus.req = 2'b00;
    idle_cycles(2 * HOLD + 4);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
